// File: rtl/data_cache_pkg.sv
// Shared types for the data cache: access sizes, controller states and the
// byte-enable decode used for partial stores.
package data_cache_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

   // Lane mask for a store; the reserved size code behaves as a full word.
   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << offset;
         SIZE_HALF: be = 4'b0011 << offset;
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/data_cache_cache_line_array.sv
// Direct-mapped line storage: resettable valid bits plus unreset tag/data
// arrays with a full-line fill port and a byte-enable store port.
module cache_line_array #(
   parameter int ADDRESS_LENGTH = 32,
   parameter int SET_BITS       = 3,
   parameter int TAG_BITS       = ADDRESS_LENGTH - SET_BITS - 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SET_BITS-1:0]       index,
   input  logic [TAG_BITS-1:0]       tag,
   input  logic                      inv_all,
   input  logic                      fill_en,
   input  logic [ADDRESS_LENGTH-1:0] fill_data,
   input  logic                      store_en,
   input  logic [3:0]                store_be,
   input  logic [ADDRESS_LENGTH-1:0] store_data,
   output logic                      hit,
   output logic [ADDRESS_LENGTH-1:0] line_data
);
   localparam int LINES = 1 << SET_BITS;

   logic [LINES-1:0]          valid_r;
   logic [TAG_BITS-1:0]       tag_r  [LINES];
   logic [ADDRESS_LENGTH-1:0] data_r [LINES];

   assign hit       = valid_r[index] && (tag_r[index] == tag);
   assign line_data = data_r[index];

   // Valid bits; invalidate-all wins over a fill landing in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
      end else if (inv_all) begin
         valid_r <= '0;
      end else if (fill_en) begin
         valid_r[index] <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Tag and data payload; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_r[index]  <= tag;
         data_r[index] <= fill_data;
      end else if (store_en) begin
         for (int i = 0; i < 4; i++) begin
            if (store_be[i]) begin
               data_r[index][8*i +: 8] <= store_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a two-state
// fill controller, memory store strobe decode and load hit/miss statistics.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int ADDRESS_LENGTH = 32,
   parameter int SET_BITS       = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cpu_re,
   input  logic                      cpu_we,
   input  logic [1:0]                cpu_size,
   input  logic [ADDRESS_LENGTH-1:0] cpu_a,
   input  logic [ADDRESS_LENGTH-1:0] cpu_wd,
   output logic [ADDRESS_LENGTH-1:0] cpu_rd,
   output logic                      stall,
   input  logic                      flush,
   output logic [ADDRESS_LENGTH-1:0] mem_a,
   output logic [ADDRESS_LENGTH-1:0] mem_wd,
   output logic                      mem_sw,
   output logic                      mem_sh,
   output logic                      mem_sb,
   input  logic [ADDRESS_LENGTH-1:0] mem_rd,
   output logic [31:0]               hit_cnt,
   output logic [31:0]               miss_cnt
);
   localparam int TAG_BITS = ADDRESS_LENGTH - SET_BITS - 2;

   state_e                    state_r;
   logic [31:0]               hit_cnt_r;
   logic [31:0]               miss_cnt_r;
   logic                      hit_s;
   logic [ADDRESS_LENGTH-1:0] line_data_s;
   logic                      fill_en_s;
   logic                      store_en_s;
   logic                      load_s;
   logic [3:0]                store_be_s;
   logic [ADDRESS_LENGTH-1:0] store_data_s;

   // A simultaneous load and store request is a store.
   assign load_s       = cpu_re && !cpu_we;
   assign store_be_s   = byte_enable(cpu_size, cpu_a[1:0]);
   assign store_data_s = cpu_wd << {cpu_a[1:0], 3'b000};
   assign mem_wd       = cpu_wd;
   assign hit_cnt      = hit_cnt_r;
   assign miss_cnt     = miss_cnt_r;

   cache_line_array #(
      .ADDRESS_LENGTH (ADDRESS_LENGTH),
      .SET_BITS       (SET_BITS),
      .TAG_BITS       (TAG_BITS)
   ) u_lines (
      .clk        (clk),
      .rst_n      (rst_n),
      .index      (cpu_a[SET_BITS+1:2]),
      .tag        (cpu_a[ADDRESS_LENGTH-1:SET_BITS+2]),
      .inv_all    (flush),
      .fill_en    (fill_en_s),
      .fill_data  (mem_rd),
      .store_en   (store_en_s),
      .store_be   (store_be_s),
      .store_data (store_data_s),
      .hit        (hit_s),
      .line_data  (line_data_s)
   );

   // CPU/memory side decode; reset masks everything so outputs drop at once.
   always_comb begin
      stall      = 1'b0;
      cpu_rd     = '0;
      mem_a      = cpu_a;
      mem_sw     = 1'b0;
      mem_sh     = 1'b0;
      mem_sb     = 1'b0;
      fill_en_s  = 1'b0;
      store_en_s = 1'b0;
      if (!rst_n) begin
         stall = 1'b0;
      end else if (state_r == FILL) begin
         stall     = 1'b1;
         mem_a     = {cpu_a[ADDRESS_LENGTH-1:2], 2'b00};
         fill_en_s = 1'b1;
      end else if (cpu_we) begin
         case (cpu_size)
            SIZE_BYTE: mem_sb = 1'b1;
            SIZE_HALF: mem_sh = 1'b1;
            default:   mem_sw = 1'b1;
         endcase
         store_en_s = hit_s;
      end else if (cpu_re) begin
         if (hit_s) begin
            cpu_rd = line_data_s;
         end else begin
            stall = 1'b1;
         end
      end else begin
         cpu_rd = '0;
      end
   end

   // Fill controller and load statistics; a fill always lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         hit_cnt_r  <= 32'd0;
         miss_cnt_r <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (load_s && !hit_s) begin
                  state_r    <= FILL;
                  miss_cnt_r <= miss_cnt_r + 32'd1;
               end else if (load_s) begin
                  state_r   <= IDLE;
                  hit_cnt_r <= hit_cnt_r + 32'd1;
               end else begin
                  state_r <= IDLE;
               end
            end
            FILL:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboarded random bench for data_cache: expected load data comes from a
// flat memory image, hit/miss and stall counts from a tag-per-line model.
module tb_data_cache;
   import data_cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_re, cpu_we, flush;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_a, cpu_wd, cpu_rd, mem_a, mem_wd, mem_rd, hit_cnt, miss_cnt;
   logic        stall, mem_sw, mem_sh, mem_sb;

   always #5 clk = ~clk;

   data_cache #(.ADDRESS_LENGTH(32), .SET_BITS(3)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_size(cpu_size),
      .cpu_a(cpu_a), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall), .flush(flush),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_sw(mem_sw), .mem_sh(mem_sh), .mem_sb(mem_sb),
      .mem_rd(mem_rd), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // Backing memory seen by the DUT (32 words at 0x00010000) and the reference image.
   logic [31:0] env_mem [0:31];
   logic [31:0] ref_mem [0:31];
   assign mem_rd = env_mem[mem_a[6:2]];

   always @(posedge clk) begin
      if (mem_sw) begin
         env_mem[mem_a[6:2]] <= mem_wd;
      end else if (mem_sh) begin
         env_mem[mem_a[6:2]][8*mem_a[1:0] +: 16] <= mem_wd[15:0];
      end else if (mem_sb) begin
         env_mem[mem_a[6:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
      end
   end

   typedef struct {
      bit          is_store;
      logic [31:0] rd;
      int          stalls;
      logic [2:0]  strobes;
      logic [31:0] a;
      logic [31:0] wd;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          m_valid [8];
   logic [26:0] m_tag   [8];
   int unsigned m_hits, m_miss;
   int          stall_run = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_counters(input string tag);
      check32({tag, "_hit_cnt"}, hit_cnt, m_hits);
      check32({tag, "_miss_cnt"}, miss_cnt, m_miss);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_hits = 0;
      m_miss = 0;
   endtask

   // Monitor: a request completes on the first sampled cycle without stall.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stall_run = 0;
      end else if (cpu_re || cpu_we) begin
         if (stall) begin
            stall_run++;
            check32("strobes_while_stalled", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
         end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got request at %h, expected none", cpu_a);
            stall_run = 0;
         end else begin
            e = exp_q.pop_front();
            check32("stall_cycles", stall_run, e.stalls);
            if (e.is_store) begin
               check32("store_strobes", {29'd0, mem_sw, mem_sh, mem_sb}, {29'd0, e.strobes});
               check32("store_mem_a", mem_a, e.a);
               check32("store_mem_wd", mem_wd, e.wd);
            end else begin
               check32("load_cpu_rd", cpu_rd, e.rd);
               check32("load_strobes", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
            end
            stall_run = 0;
         end
      end else begin
         stall_run = 0;
         check32("idle_cpu_rd", cpu_rd, 32'd0);
         check32("idle_stall", {31'd0, stall}, 32'd0);
         check32("idle_mem_a", mem_a, cpu_a);
         check32("idle_strobes", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
      end
   end

   // Drive one request at posedge+1 and hold it until it completes.
   task automatic present(input bit re, input bit we, input logic [1:0] size,
                          input logic [31:0] a, input logic [31:0] wd, input bit flush_in_fill);
      int n = 0;
      cpu_re = re; cpu_we = we; cpu_size = size; cpu_a = a; cpu_wd = wd;
      if (flush_in_fill) begin
         @(negedge clk);
         @(posedge clk); #1 flush = 1'b1;
         @(posedge clk); #1 flush = 1'b0;
      end
      do begin
         @(negedge clk);
         n++;
      end while (stall && n < 20);
      if (stall) begin
         checks++;
         errors++;
         $display("FAIL stall_timeout: got stall after %0d cycles at %h, expected release", n, a);
      end
      @(posedge clk); #1;
      cpu_re = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input bit with_flush);
      exp_t e;
      int idx = int'(a[4:2]);
      bit hit = m_valid[idx] && (m_tag[idx] == a[31:5]);
      e.is_store = 1'b0; e.rd = ref_mem[a[6:2]]; e.strobes = 3'b000; e.a = a; e.wd = 32'd0;
      if (hit) begin
         e.stalls = 0;
         m_hits++;
      end else begin
         if (with_flush) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            e.stalls = 4;
            m_miss += 2;
         end else begin
            e.stalls = 2;
            m_miss += 1;
         end
         m_hits++;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = a[31:5];
      end
      exp_q.push_back(e);
      present(1'b1, 1'b0, 2'b10, a, 32'd0, with_flush && !hit);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [1:0] size,
                           input logic [31:0] wd, input bit also_re);
      exp_t e;
      case (size)
         2'b00:   ref_mem[a[6:2]][8*a[1:0] +: 8]  = wd[7:0];
         2'b01:   ref_mem[a[6:2]][8*a[1:0] +: 16] = wd[15:0];
         default: ref_mem[a[6:2]] = wd;
      endcase
      e.is_store = 1'b1; e.rd = 32'd0; e.stalls = 0; e.a = a; e.wd = wd;
      e.strobes  = (size == 2'b00) ? 3'b001 : (size == 2'b01) ? 3'b010 : 3'b100;
      exp_q.push_back(e);
      present(also_re, 1'b1, size, a, wd, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] v, a;
      logic [1:0]  sz;
      int          r;
      for (int i = 0; i < 32; i++) begin
         v = $urandom;
         env_mem[i] = v;
         ref_mem[i] = v;
      end
      env_mem[0] = 32'hDEADBEEF;
      ref_mem[0] = 32'hDEADBEEF;
      rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; flush = 1'b0;
      cpu_size = 2'b10; cpu_a = 32'h00010000; cpu_wd = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check32("reset_stall", {31'd0, stall}, 32'd0);
      check32("reset_cpu_rd", cpu_rd, 32'd0);
      check32("reset_strobes", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
      check_counters("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      do_load(32'h00010000, 1'b0);
      check_counters("first_miss");
      do_load(32'h00010000, 1'b0);
      check_counters("repeat_hit");
      do_store(32'h00010001, 2'b00, 32'h00000055, 1'b0);
      do_load(32'h00010000, 1'b0);
      check32("byte_merge_ref", ref_mem[0], 32'hDEAD55EF);
      do_load(32'h00010020, 1'b0);
      do_load(32'h00010000, 1'b0);
      check_counters("conflict");
      do_store(32'h00010040, 2'b10, 32'hCAFEF00D, 1'b1);
      check_counters("re_and_we");
      do_load(32'h00010020, 1'b1);
      check_counters("flush_in_fill");

      // Reset mid-fill with the load still held.
      cpu_re = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_a = 32'h00010004;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check32("rst_fill_stall", {31'd0, stall}, 32'd0);
      check32("rst_fill_cpu_rd", cpu_rd, 32'd0);
      model_reset();
      check_counters("rst_fill");
      cpu_re = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      do_load(32'h00010004, 1'b0);
      check_counters("after_rst_fill");

      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 9);
         a = 32'h00010000 | $urandom_range(0, 127);
         if (r <= 4) begin
            do_load(a, 1'b0);
         end else begin
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'b01) a = a & 32'hFFFFFFFE;
            else if (sz != 2'b00) a = a & 32'hFFFFFFFC;
            do_store(a, sz, $urandom, r == 9);
         end
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      check_counters("final");
      check32("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The parameter list SHALL be: ADDRESS_LENGTH, 32, address and data width; SET_BITS, 3, log2 of the number of lines (8 lines, one 32-bit word each).
REQ-002 The port list SHALL be, in order:
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  cpu_re  in  1  load request
  cpu_we  in  1  store request
  cpu_size  in  2  00 byte, 01 half, 10 word (11 reserved, treated as word)
  cpu_a  in  ADDRESS_LENGTH  byte address
  cpu_wd  in  ADDRESS_LENGTH  store data, right-aligned
  cpu_rd  out  ADDRESS_LENGTH  word-aligned load data
  stall  out  1  CPU must hold its request
  flush  in  1  invalidate all lines
  mem_a  out  ADDRESS_LENGTH  memory address
  mem_wd  out  ADDRESS_LENGTH  memory store data
  mem_sw / mem_sh / mem_sb  out  1 each  memory word/half/byte store strobes
  mem_rd  in  ADDRESS_LENGTH  memory read data, combinational in mem_a
  hit_cnt / miss_cnt  out  32 each  load statistics
REQ-003 The block SHALL have one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-004 Organisation SHALL be direct-mapped, write-through, no-write-allocate; index = cpu_a[SET_BITS+1:2]; tag = cpu_a[31:SET_BITS+2].
REQ-005 The FSM SHALL have states IDLE and FILL.
REQ-006 IDLE, load hit (valid & tag match): cpu_rd = line data combinationally, stall=0, hit_cnt+1 at the edge.
REQ-007 IDLE, load miss: stall=1 in the same cycle, miss_cnt+1, next state FILL.
REQ-008 FILL: mem_a = {cpu_a[31:2],2'b00}; at the edge capture mem_rd into the line, set valid, write tag; stall=1; next state IDLE. The re-presented load hits one cycle later, giving a total miss penalty of 2 stall cycles.
REQ-009 Store, any state except FILL: mem_a=cpu_a, mem_wd=cpu_wd, exactly one of mem_sb/mem_sh/mem_sw asserted per cpu_size, no stall.
REQ-010 Store hit: update only the addressed bytes of the line (byte lane cpu_a[1:0]; half at lanes a, a+1). Store miss: leave the line unchanged.
REQ-011 Memory strobes SHALL be 0 whenever cpu_we=0 or state=FILL.
REQ-012 cpu_re and cpu_we both high SHALL be treated as a store; hit_cnt and miss_cnt SHALL not change.
REQ-013 flush SHALL clear all valid bits at the edge and take priority over a fill completing in the same cycle: the line is left invalid and the FSM returns to IDLE.
REQ-014 Counters SHALL wrap modulo 2^32.
REQ-015 With no request: cpu_rd = 0, stall = 0, mem_a = cpu_a.
REQ-016 Misaligned half/word accesses are undefined; no checking is required.

Reset
REQ-017 rst_n low SHALL immediately force: state IDLE, all valid bits 0, hit_cnt=0, miss_cnt=0, stall=0, strobes 0, cpu_rd=0.
REQ-018 Reset asserted during FILL SHALL abort the fill; the line stays invalid.
REQ-019 Tag and data arrays SHALL need no reset.

Structure
REQ-020 A shared package SHALL hold the access-size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state enum.
REQ-021 A single sub-module cache_line_array SHALL implement valid/tag/data storage with a byte-enable write port; the FSM, counters and memory-strobe decode SHALL stay in data_cache.

Verification
REQ-022 Reset, then load 0x00010000 (mem holds 0xDEADBEEF) -> stall 1,1 then 0; cpu_rd=0xDEADBEEF; miss_cnt=1, hit_cnt=1.
REQ-023 Repeat the load of REQ-022 -> stall 0 the same cycle; hit_cnt=2.
REQ-024 Store byte 0x55 to 0x00010001 after REQ-022 -> mem_sb=1 for one cycle; next load returns 0xDEAD55EF.
REQ-025 Load 0x00010020 (same index, different tag) after REQ-022 -> miss; line replaced; reload of 0x00010000 misses again.
REQ-026 Assert flush in the FILL cycle -> state returns to IDLE; a reload of the same address misses.
REQ-027 Drop rst_n mid-FILL -> stall=0 and counters 0 immediately; the next load misses.
